// File: rtl/senseye_ahb_pkg.sv
// rtl/senseye_ahb_pkg.sv - register map, bit indices, HTRANS codes and FSM states
// ERR1/ERR2 states exist only when AHB_ERR_RESP_EN is defined.
package senseye_ahb_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_DATA   = 8'h08;
  localparam logic [7:0] OFF_THRESH = 8'h0C;

  localparam int CTRL_CAP_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 3;
  localparam int ST_LEVEL_LSB = 16;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_POP,
    S_RD_DATA,
    S_WAIT_EMPTY
`ifdef AHB_ERR_RESP_EN
    , S_ERR1,
    S_ERR2
`endif
  } fsm_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock word FIFO with registered read, flush and level count
module sync_fifo #(
  parameter int DEPTH = 512,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
    if (do_pop)  rdata <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/ahb_pixel_fifo_slave.sv
// rtl/ahb_pixel_fifo_slave.sv - AHB-Lite slave packing camera pixels into a word FIFO
// AHB_ERR_RESP_EN: unmapped accesses and empty-FIFO timeouts answer with a two-cycle ERROR.
module ahb_pixel_fifo_slave
  import senseye_ahb_pkg::*;
#(
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_W     = 8,
  parameter int WAIT_MAX   = 64
) (
  input  logic              SYSCLK,
  input  logic              SYSRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  input  logic              PIX_VALID,
  input  logic [7:0]        PIX_DATA,
  input  logic              PIX_SOF,
  output logic              IRQ
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] IDX_CTRL   = IW'(OFF_CTRL >> 2);
  localparam logic [IW-1:0] IDX_STATUS = IW'(OFF_STATUS >> 2);
  localparam logic [IW-1:0] IDX_DATA   = IW'(OFF_DATA >> 2);
  localparam logic [IW-1:0] IDX_THRESH = IW'(OFF_THRESH >> 2);

`ifdef AHB_ERR_RESP_EN
  localparam fsm_state_e TIMEOUT_NX  = S_ERR1;
  localparam logic       TIMEOUT_RDY = 1'b0;
`else
  localparam fsm_state_e TIMEOUT_NX  = S_IDLE;
  localparam logic       TIMEOUT_RDY = 1'b1;
`endif

  fsm_state_e    state;
  fsm_state_e    state_nx;
  logic          hready;
  logic          accept;
  logic          timeout;
  logic [CW-1:0] wait_cnt;
  logic [IW-1:0] haddr_idx;
  logic [IW-1:0] idx_q;
  logic          dph;
  logic          wr_q;
  logic          wr_en;
  logic          wr_status;

  logic          cap_en;
  logic          irq_en;
  logic          ovf;
  logic          unf;
  logic          irq_q;
  logic [15:0]   thresh;

  logic [1:0]    lane;
  logic [23:0]   part;
  logic          fifo_push;
  logic          fifo_pop;
  logic          flush;
  logic [31:0]   fifo_rdata;
  logic [LW-1:0] level;
  logic [15:0]   level16;
  logic          full;
  logic          empty;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign haddr_idx   = HADDR[ADDR_W-1:2];
  assign accept      = HSEL & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ)) & hready;
  assign timeout     = (state == S_WAIT_EMPTY) && (wait_cnt == CW'(WAIT_MAX));
  assign wr_en       = dph & wr_q & hready;
  assign wr_status   = wr_en & (idx_q == IDX_STATUS);
  assign flush       = wr_en & (idx_q == IDX_CTRL) & HWDATA[CTRL_FLUSH];
  assign fifo_pop    = (state == S_RD_POP);
  assign level16     = 16'(level);
  assign status_word = {level16, 12'h000, unf, ovf, full, empty};
  assign unused_bits = ^{HSIZE, HADDR[1:0], HWDATA[31:16]};

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (SYSCLK),
    .rst   (SYSRESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .wdata ({PIX_DATA, part}),
    .rdata (fifo_rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      dph      <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (state == S_WAIT_EMPTY && !timeout && state_nx == S_WAIT_EMPTY) ?
                  wait_cnt + CW'(1) : '0;
      if (hready) begin
        dph   <= accept;
        wr_q  <= HWRITE;
        idx_q <= haddr_idx;
      end
    end
  end

  always_comb begin
    hready = 1'b1;
    case (state)
      S_RD_POP:     hready = 1'b0;
      S_WAIT_EMPTY: hready = timeout ? TIMEOUT_RDY : 1'b0;
`ifdef AHB_ERR_RESP_EN
      S_ERR1:       hready = 1'b0;
`endif
      default:      hready = 1'b1;
    endcase
  end

`ifdef AHB_ERR_RESP_EN
  logic mapped;
  assign mapped = (haddr_idx == IDX_CTRL) | (haddr_idx == IDX_STATUS) |
                  (haddr_idx == IDX_DATA) | (haddr_idx == IDX_THRESH);
`endif

  // A new address phase accepted while HREADY=1 overrides the completing state.
  always_comb begin
    state_nx = state;
    case (state)
      S_RD_POP:     state_nx = S_RD_DATA;
      S_RD_DATA:    state_nx = S_IDLE;
      S_WAIT_EMPTY: begin
        if (timeout)     state_nx = TIMEOUT_NX;
        else if (!empty) state_nx = S_RD_POP;
      end
`ifdef AHB_ERR_RESP_EN
      S_ERR1:       state_nx = S_ERR2;
      S_ERR2:       state_nx = S_IDLE;
`endif
      default:      state_nx = S_IDLE;
    endcase
    if (accept) begin
      if (!HWRITE && haddr_idx == IDX_DATA) state_nx = empty ? S_WAIT_EMPTY : S_RD_POP;
`ifdef AHB_ERR_RESP_EN
      else if (!mapped)                     state_nx = S_ERR1;
`endif
      else                                  state_nx = S_IDLE;
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (state == S_RD_DATA) begin
      HRDATA = fifo_rdata;
    end else if (state == S_IDLE && dph && !wr_q) begin
      case (idx_q)
        IDX_CTRL:   HRDATA = {29'h0, irq_en, 1'b0, cap_en};
        IDX_STATUS: HRDATA = status_word;
        IDX_THRESH: HRDATA = {16'h0, thresh};
        default:    HRDATA = 32'h0;
      endcase
    end
  end

  assign HREADY = hready;
`ifdef AHB_ERR_RESP_EN
  assign HRESP  = (state == S_ERR1) | (state == S_ERR2);
`else
  assign HRESP  = 1'b0;
`endif
  assign IRQ    = irq_q;

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      cap_en <= 1'b0;
      irq_en <= 1'b0;
      thresh <= 16'h0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && idx_q == IDX_CTRL) begin
        cap_en <= HWDATA[CTRL_CAP_EN];
        irq_en <= HWDATA[CTRL_IRQ_EN];
      end
      if (wr_en && idx_q == IDX_THRESH) thresh <= HWDATA[15:0];
      // New events win over a same-cycle write-one-to-clear.
      ovf   <= (ovf & ~(wr_status & HWDATA[ST_OVERFLOW])) | (fifo_push & full);
      unf   <= (unf & ~(wr_status & HWDATA[ST_UNDERFLOW])) | timeout;
      irq_q <= irq_en & (level16 >= thresh) & (thresh != 16'h0);
    end
  end

  assign fifo_push = cap_en & PIX_VALID & ~PIX_SOF & (lane == 2'd3) & ~flush;

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET || flush) begin
      lane <= 2'd0;
      part <= 24'h0;
    end else if (cap_en && PIX_VALID) begin
      if (PIX_SOF) begin
        part <= {16'h0, PIX_DATA};
        lane <= 2'd1;
      end else begin
        case (lane)
          2'd0:    part[7:0]   <= PIX_DATA;
          2'd1:    part[15:8]  <= PIX_DATA;
          2'd2:    part[23:16] <= PIX_DATA;
          default: part        <= part;
        endcase
        lane <= lane + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_pixel_fifo_slave.sv
// tb/tb_ahb_pixel_fifo_slave.sv - randomized self-checking bench for ahb_pixel_fifo_slave
module tb_ahb_pixel_fifo_slave;

  localparam int DEPTH = 512;
  localparam int WMAX  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic [7:0]  haddr = 8'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = 32'h0;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'h0;
  logic        pix_sof = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  ahb_pixel_fifo_slave #(.FIFO_DEPTH(DEPTH), .ADDR_W(8), .WAIT_MAX(WMAX)) dut (
    .SYSCLK(clk), .SYSRESET(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata), .HREADY(hready),
    .HRESP(hresp), .PIX_VALID(pix_valid), .PIX_DATA(pix_data), .PIX_SOF(pix_sof), .IRQ(irq)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_fifo[$];
  logic [7:0]  m_pend[$];
  logic        m_cap, m_irq_en, m_ovf, m_unf;
  logic [15:0] m_thresh;

`ifdef AHB_ERR_RESP_EN
  localparam int  TO_WAITS = WMAX + 2;
  localparam logic ERR_RESP = 1'b1;
`else
  localparam int  TO_WAITS = WMAX;
  localparam logic ERR_RESP = 1'b0;
`endif

  task automatic m_reset();
    m_fifo.delete(); m_pend.delete();
    m_cap = 0; m_irq_en = 0; m_ovf = 0; m_unf = 0; m_thresh = 16'h0;
  endtask

  function automatic logic [31:0] m_status();
    int n = m_fifo.size();
    return {16'(n), 12'h000, m_unf, m_ovf, logic'(n == DEPTH), logic'(n == 0)};
  endfunction

  function automatic logic m_irq();
    return m_irq_en && (m_thresh != 0) && (m_fifo.size() >= int'(m_thresh));
  endfunction

  // Expected outcome of one DATA read: the oldest word, or a timed-out zero.
  task automatic m_pop(output logic [31:0] d, output int w);
    if (m_fifo.size() > 0) begin d = m_fifo.pop_front(); w = 1; end
    else begin d = 32'h0; w = TO_WAITS; m_unf = 1; end
  endtask

  task automatic send_pix(input logic [7:0] b, input logic sof);
    pix_valid = 1; pix_data = b; pix_sof = sof;
    @(posedge clk); #1;
    pix_valid = 0; pix_sof = 0;
    if (m_cap) begin
      if (sof) begin m_pend.delete(); m_pend.push_back(b); end
      else begin
        m_pend.push_back(b);
        if (m_pend.size() == 4) begin
          if (m_fifo.size() == DEPTH) m_ovf = 1;
          else m_fifo.push_back({m_pend[3], m_pend[2], m_pend[1], m_pend[0]});
          m_pend.delete();
        end
      end
    end
  endtask

  task automatic ahb_xfer(input logic [7:0] a, input logic wr, input logic [31:0] wd,
                          output logic [31:0] d, output int waits, output logic resp);
    hsel = 1; htrans = 2'b10; hwrite = wr; haddr = a;
    @(posedge clk); #1;
    hsel = 0; htrans = 2'b00; hwdata = wd; waits = 0;
    while (hready !== 1'b1 && waits < 300) begin @(posedge clk); #1; waits++; end
    if (waits >= 300) begin
      n_vec++; n_err++;
      $display("FAIL hready_timeout: addr %h stuck low for %0d cycles, want completion", a, waits);
    end
    d = hrdata; resp = hresp;
    @(posedge clk); #1;
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] wd);
    logic [31:0] d; int w; logic r;
    ahb_xfer(a, 1'b1, wd, d, w, r);
  endtask

  task automatic wr_ctrl(input logic cap, input logic fl, input logic ie);
    ahb_write(8'h00, {29'h0, ie, fl, cap});
    m_cap = cap; m_irq_en = ie;
    if (fl) begin m_fifo.delete(); m_pend.delete(); end
  endtask

  task automatic test_reset();
    logic [31:0] d; int w; logic r;
    rst = 1; repeat (3) @(posedge clk); #1; rst = 0; m_reset();
    n_vec++; if (hready !== 1'b1) begin n_err++; $display("FAIL reset_hready: got %b want 1", hready); end
    n_vec++; if (hresp !== 1'b0) begin n_err++; $display("FAIL reset_hresp: got %b want 0", hresp); end
    n_vec++; if (hrdata !== 32'h0) begin n_err++; $display("FAIL reset_hrdata: got %h want 0", hrdata); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    ahb_xfer(8'h04, 0, 0, d, w, r);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL reset_status: got %h want 00000001", d); end
    n_vec++; if (w != 0 || r !== 1'b0) begin n_err++; $display("FAIL reset_status_timing: waits %0d resp %b want 0/0", w, r); end
  endtask

  task automatic test_basic_pack();
    logic [31:0] d; int w; logic r;
    wr_ctrl(1, 0, 0);
    send_pix(8'h11, 0); send_pix(8'h22, 0); send_pix(8'h33, 0); send_pix(8'h44, 0);
    ahb_xfer(8'h04, 0, 0, d, w, r);
    n_vec++; if (d !== 32'h0001_0000) begin n_err++; $display("FAIL pack_level: got %h want 00010000", d); end
    ahb_xfer(8'h08, 0, 0, d, w, r); void'(m_fifo.pop_front());
    n_vec++; if (d !== 32'h4433_2211) begin n_err++; $display("FAIL pack_word: got %h want 44332211", d); end
    n_vec++; if (w != 1) begin n_err++; $display("FAIL pack_waits: got %0d want 1", w); end
    ahb_xfer(8'h04, 0, 0, d, w, r);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL pack_drained: got %h want 00000001", d); end
  endtask

  task automatic test_underflow();
    logic [31:0] d, ed; int w, ew; logic r;
    ahb_xfer(8'h08, 0, 0, d, w, r); m_pop(ed, ew);
    n_vec++; if (d !== ed || w != ew) begin n_err++; $display("FAIL underflow_read: data %h waits %0d want %h/%0d", d, w, ed, ew); end
    n_vec++; if (r !== ERR_RESP) begin n_err++; $display("FAIL underflow_resp: got %b want %b", r, ERR_RESP); end
    ahb_xfer(8'h04, 0, 0, d, w, r);
    n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL underflow_flag: got %h want %h", d, m_status()); end
    ahb_write(8'h04, 32'h8); m_unf = 0;
    ahb_xfer(8'h04, 0, 0, d, w, r);
    n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL underflow_w1c: got %h want %h", d, m_status()); end
  endtask

  task automatic test_random_stream();
    logic [31:0] d, ed; int w, ew; logic r;
    for (int rnd = 0; rnd < 8; rnd++) begin
      wr_ctrl(logic'($urandom_range(0, 3) != 0), 0, 0);
      for (int i = $urandom_range(1, 40); i > 0; i--)
        send_pix(8'($urandom), logic'($urandom_range(0, 11) == 0));
      ahb_xfer(8'h04, 0, 0, d, w, r);
      n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL rand_status[%0d]: got %h want %h", rnd, d, m_status()); end
      for (int k = $urandom_range(0, m_fifo.size()); k > 0; k--) begin
        ahb_xfer(8'h08, 0, 0, d, w, r); m_pop(ed, ew);
        n_vec++; if (d !== ed || w != ew) begin n_err++; $display("FAIL rand_data[%0d]: got %h/%0d want %h/%0d", rnd, d, w, ed, ew); end
      end
    end
    while (m_fifo.size() > 0) begin
      ahb_xfer(8'h08, 0, 0, d, w, r); m_pop(ed, ew);
      n_vec++; if (d !== ed) begin n_err++; $display("FAIL rand_drain: got %h want %h", d, ed); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, ed; int w, ew; logic r;
    wr_ctrl(1, 1, 0);
    for (int i = 0; i < (DEPTH + 1) * 4; i++) send_pix(8'($urandom), 0);
    ahb_xfer(8'h04, 0, 0, d, w, r);
    n_vec++; if (d !== 32'h0200_0006) begin n_err++; $display("FAIL ovf_status: got %h want 02000006", d); end
    ahb_xfer(8'h08, 0, 0, d, w, r); m_pop(ed, ew);
    n_vec++; if (d !== ed) begin n_err++; $display("FAIL ovf_first_word: got %h want %h", d, ed); end
    wr_ctrl(0, 1, 0);
    ahb_xfer(8'h04, 0, 0, d, w, r);
    n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL flush_status: got %h want %h", d, m_status()); end
    ahb_write(8'h04, 32'h4); m_ovf = 0;
    ahb_xfer(8'h04, 0, 0, d, w, r);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL ovf_w1c: got %h want 00000001", d); end
  endtask

  task automatic test_sof();
    logic [31:0] d; int w; logic r;
    wr_ctrl(1, 1, 0);
    for (int i = 0; i < 3; i++) send_pix(8'($urandom), 0);
    send_pix(8'hAA, 1); send_pix(8'hBB, 0); send_pix(8'hCC, 0); send_pix(8'hDD, 0);
    ahb_xfer(8'h04, 0, 0, d, w, r);
    n_vec++; if (d !== 32'h0001_0000) begin n_err++; $display("FAIL sof_level: got %h want 00010000", d); end
    ahb_xfer(8'h08, 0, 0, d, w, r); void'(m_fifo.pop_front());
    n_vec++; if (d !== 32'hDDCC_BBAA) begin n_err++; $display("FAIL sof_word: got %h want DDCCBBAA", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d, ed; int w, ew; logic r;
    ahb_write(8'h0C, 32'h2); m_thresh = 16'h2;
    wr_ctrl(1, 1, 1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) send_pix(8'($urandom), 0);
      repeat (2) @(posedge clk); #1;
      n_vec++; if (irq !== m_irq()) begin n_err++; $display("FAIL irq_level[%0d]: got %b want %b", p, irq, m_irq()); end
      if (p == 1) begin
        ahb_xfer(8'h08, 0, 0, d, w, r); m_pop(ed, ew);
        repeat (2) @(posedge clk); #1;
        n_vec++; if (irq !== m_irq()) begin n_err++; $display("FAIL irq_after_pop: got %b want %b", irq, m_irq()); end
        ahb_write(8'h0C, 32'h0); m_thresh = 16'h0;
      end
    end
    ahb_xfer(8'h00, 0, 0, d, w, r);
    n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL ctrl_readback: got %h want 00000005", d); end
    wr_ctrl(0, 1, 0);
  endtask

  task automatic test_unmapped();
    logic [31:0] d; int w; logic r;
    ahb_write(8'h0C, 32'hABCD_1234); m_thresh = 16'h1234;
    ahb_write(8'h20, $urandom);
    ahb_xfer(8'h0C, 0, 0, d, w, r);
    n_vec++; if (d !== 32'h0000_1234) begin n_err++; $display("FAIL thresh_readback: got %h want 00001234", d); end
    ahb_xfer(8'h20, 0, 0, d, w, r);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_data: got %h want 0", d); end
`ifdef AHB_ERR_RESP_EN
    n_vec++; if (w != 1 || r !== 1'b1) begin n_err++; $display("FAIL unmapped_err: waits %0d resp %b want 1/1", w, r); end
`else
    n_vec++; if (w != 0 || r !== 1'b0) begin n_err++; $display("FAIL unmapped_okay: waits %0d resp %b want 0/0", w, r); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; int w; logic r;
    hsel = 1; htrans = 2'b10; hwrite = 0; haddr = 8'h08;
    @(posedge clk); #1; hsel = 0; htrans = 2'b00;
    repeat (5) @(posedge clk); #1;
    n_vec++; if (hready !== 1'b0) begin n_err++; $display("FAIL mid_wait: got %b want 0", hready); end
    rst = 1; @(posedge clk); #1; rst = 0; m_reset();
    n_vec++; if (hready !== 1'b1) begin n_err++; $display("FAIL mid_abort: got %b want 1", hready); end
    ahb_xfer(8'h04, 0, 0, d, w, r);
    n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL mid_status: got %h want %h", d, m_status()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_pack();
    test_underflow();
    test_random_stream();
    test_overflow();
    test_sof();
    test_irq();
    test_unmapped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
